// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and defaults for the register-bank writeback arbiter.
package regfile_wb_arbiter_pkg;

    localparam int unsigned DEF_ADDR_W = 4;
    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_DEPTH  = 16;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_hold_slot.sv
// One-entry writeback holding register with a valid/ready input handshake.
module wb_hold_slot #(
    parameter int unsigned W = 36
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         run_next,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_payload,
    input  logic         clear,
    output logic         full,
    output logic [W-1:0] payload
);

    logic accept;
    logic full_next;

    always_comb begin
        accept    = in_valid && in_ready;
        full_next = accept || (full && !clear);
    end

    // ready is registered from the next-cycle occupancy so it never depends on in_valid
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            full     <= 1'b0;
            in_ready <= 1'b0;
            payload  <= '0;
        end else begin
            full     <= full_next;
            in_ready <= run_next && !full_next;
            if (accept)
                payload <= in_payload;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin merge of two writeback sources onto one register-bank write port.
// Define REGFILE_WB_ARBITER_SCRUB_EN to zero the whole bank after reset before RUN.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned DEPTH  = DEF_DEPTH
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              we,
    output logic [ADDR_W-1:0] write_addr,
    output logic [DATA_W-1:0] write_data,
    output logic              init_done
);

    localparam int unsigned W = ADDR_W + DATA_W;

    if (DEPTH > (1 << ADDR_W)) begin : g_depth_chk
        $error("DEPTH exceeds the address space");
    end

    state_t       state;
    logic         run_next;
    logic         rr_b;
    logic         a_full, b_full;
    logic         grant_a, grant_b;
    logic [W-1:0] a_hold, b_hold;

`ifdef REGFILE_WB_ARBITER_SCRUB_EN
    localparam int unsigned IDX_W = $clog2(DEPTH + 1);
    logic [IDX_W-1:0] scrub_idx;
`endif

    always_comb begin
        run_next = (state == ST_RUN);
`ifdef REGFILE_WB_ARBITER_SCRUB_EN
        if (state == ST_INIT && scrub_idx == IDX_W'(DEPTH))
            run_next = 1'b1;
`endif
        grant_a = (state == ST_RUN) && a_full && (!b_full || !rr_b);
        grant_b = (state == ST_RUN) && b_full && (!a_full || rr_b);
    end

    wb_hold_slot #(.W(W)) u_hold_a (
        .clock      (clock),
        .reset_n    (reset_n),
        .run_next   (run_next),
        .in_valid   (a_valid),
        .in_ready   (a_ready),
        .in_payload ({a_addr, a_data}),
        .clear      (grant_a),
        .full       (a_full),
        .payload    (a_hold)
    );

    wb_hold_slot #(.W(W)) u_hold_b (
        .clock      (clock),
        .reset_n    (reset_n),
        .run_next   (run_next),
        .in_valid   (b_valid),
        .in_ready   (b_ready),
        .in_payload ({b_addr, b_data}),
        .clear      (grant_b),
        .full       (b_full),
        .payload    (b_hold)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            we         <= 1'b0;
            write_addr <= '0;
            write_data <= '0;
            rr_b       <= 1'b0;
`ifdef REGFILE_WB_ARBITER_SCRUB_EN
            state      <= ST_INIT;
            scrub_idx  <= '0;
`else
            state      <= ST_RUN;
`endif
        end else begin
            case (state)
                ST_INIT: begin
`ifdef REGFILE_WB_ARBITER_SCRUB_EN
                    // index runs one past the last register so RUN is entered with we low
                    if (scrub_idx == IDX_W'(DEPTH)) begin
                        state <= ST_RUN;
                        we    <= 1'b0;
                    end else begin
                        we         <= 1'b1;
                        write_addr <= ADDR_W'(scrub_idx);
                        write_data <= '0;
                        scrub_idx  <= scrub_idx + 1'b1;
                    end
`else
                    state <= ST_RUN;
                    we    <= 1'b0;
`endif
                end
                default: begin
                    we <= grant_a || grant_b;
                    if (grant_a) begin
                        write_addr <= a_hold[DATA_W +: ADDR_W];
                        write_data <= a_hold[DATA_W-1:0];
                    end else if (grant_b) begin
                        write_addr <= b_hold[DATA_W +: ADDR_W];
                        write_data <= b_hold[DATA_W-1:0];
                    end
                    if (a_full && b_full)
                        rr_b <= !rr_b;
                end
            endcase
        end
    end

    assign init_done = (state == ST_RUN);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed steps plus random traffic against a transaction model.
module tb_regfile_wb_arbiter;
    import regfile_wb_arbiter_pkg::*;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        a_valid = 1'b0, b_valid = 1'b0;
    logic        a_ready, b_ready;
    logic [3:0]  a_addr = '0, b_addr = '0;
    logic [31:0] a_data = '0, b_data = '0;
    logic        we, init_done;
    logic [3:0]  write_addr;
    logic [31:0] write_data;

    int checks = 0;
    int errors = 0;

    // reference model: pending entries, round-robin owner, expected port values
    bit          m_ha, m_hb, m_ra, m_rb, m_ptr_b;
    wb_req_t     m_pa, m_pb;
    bit          m_we;
    logic [3:0]  m_addr;
    logic [31:0] m_data;

    regfile_wb_arbiter #(.ADDR_W(4), .DATA_W(32), .DEPTH(16)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .a_valid    (a_valid),
        .a_ready    (a_ready),
        .a_addr     (a_addr),
        .a_data     (a_data),
        .b_valid    (b_valid),
        .b_ready    (b_ready),
        .b_addr     (b_addr),
        .b_data     (b_data),
        .we         (we),
        .write_addr (write_addr),
        .write_data (write_data),
        .init_done  (init_done)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        int win;
        bit acc_a, acc_b;
        acc_a = a_valid && m_ra;
        acc_b = b_valid && m_rb;
        win = 0;
        if (m_ha && m_hb) begin
            win = m_ptr_b ? 2 : 1;
            m_ptr_b = !m_ptr_b;
        end else if (m_ha) win = 1;
        else if (m_hb) win = 2;
        m_we = (win != 0);
        if (win == 1) begin m_addr = m_pa.addr; m_data = m_pa.data; m_ha = 0; end
        if (win == 2) begin m_addr = m_pb.addr; m_data = m_pb.data; m_hb = 0; end
        if (acc_a) begin m_ha = 1; m_pa = '{addr: a_addr, data: a_data}; end
        if (acc_b) begin m_hb = 1; m_pb = '{addr: b_addr, data: b_data}; end
        m_ra = !m_ha;
        m_rb = !m_hb;
        @(posedge clock); #1;
        check("we", we, m_we);
        check("write_addr", write_addr, m_addr);
        check("write_data", write_data, m_data);
        check("a_ready", a_ready, m_ra);
        check("b_ready", b_ready, m_rb);
        check("init_done", init_done, 1);
    endtask

    task automatic scrub_seq();
`ifdef REGFILE_WB_ARBITER_SCRUB_EN
        for (int i = 0; i < int'(DEF_DEPTH); i++) begin
            @(posedge clock); #1;
            check("scrub_we", we, 1);
            check("scrub_addr", write_addr, i);
            check("scrub_data", write_data, 0);
            check("scrub_a_ready", a_ready, 0);
            check("scrub_b_ready", b_ready, 0);
            check("scrub_init_done", init_done, 0);
        end
        @(posedge clock); #1;
        check("scrub_end_we", we, 0);
        check("scrub_end_init_done", init_done, 1);
        check("scrub_end_a_ready", a_ready, 1);
        check("scrub_end_b_ready", b_ready, 1);
        m_ra = 1; m_rb = 1; m_we = 0;
        m_addr = 4'(DEF_DEPTH - 1); m_data = '0;
`else
        cycle();
`endif
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        check("rst_we", we, 0);
        check("rst_addr", write_addr, 0);
        check("rst_data", write_data, 0);
        check("rst_a_ready", a_ready, 0);
        check("rst_b_ready", b_ready, 0);
`ifdef REGFILE_WB_ARBITER_SCRUB_EN
        check("rst_init_done", init_done, 0);
`else
        check("rst_init_done", init_done, 1);
`endif
        m_ha = 0; m_hb = 0; m_ra = 0; m_rb = 0; m_ptr_b = 0;
        m_we = 0; m_addr = '0; m_data = '0;
        @(negedge clock);
        reset_n = 1'b1;
        scrub_seq();
    endtask

    initial begin
        logic [31:0] next_b;
        logic [31:0] exp_b;
        bit          was_ready;

        #12;
        do_reset();
        cycle(); cycle();

        // single source A
        a_valid = 1; a_addr = 4'd3; a_data = 32'hDEADBEEF;
        cycle();
        a_valid = 0;
        check("single_a_ready_low", a_ready, 0);
        check("single_no_we_yet", we, 0);
        cycle();
        check("single_we", we, 1);
        check("single_addr", write_addr, 3);
        check("single_data", write_data, 32'hDEADBEEF);
        check("single_a_ready_back", a_ready, 1);
        cycle();
        check("single_we_drop", we, 0);

        // conflict twice: pointer alternates
        for (int r = 0; r < 2; r++) begin
            a_valid = 1; a_addr = 4'd2; a_data = 32'h11;
            b_valid = 1; b_addr = 4'd5; b_data = 32'h22;
            cycle();
            a_valid = 0; b_valid = 0;
            cycle();
            check("conflict_first_addr", write_addr, (r == 0) ? 2 : 5);
            cycle();
            check("conflict_second_we", we, 1);
            check("conflict_second_addr", write_addr, (r == 0) ? 5 : 2);
            cycle();
        end

        // same address, pointer back at A
        a_valid = 1; a_addr = 4'd7; a_data = 32'h1;
        b_valid = 1; b_addr = 4'd7; b_data = 32'h2;
        cycle();
        a_valid = 0; b_valid = 0;
        cycle();
        check("same_first", {write_addr, write_data}, {4'd7, 32'h1});
        cycle();
        check("same_second", {write_addr, write_data}, {4'd7, 32'h2});
        cycle();

        // back-to-back on B
        next_b = 1; exp_b = 1;
        b_valid = 1; b_addr = 4'd9; b_data = next_b;
        for (int i = 0; i < 10; i++) begin
            was_ready = m_rb;
            cycle();
            if (we) begin
                check("b2b_order", write_data, exp_b);
                exp_b++;
            end
            if (was_ready) begin next_b++; b_data = next_b; end
        end
        b_valid = 0;
        cycle(); cycle();
        check("b2b_count", exp_b, 6);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            a_valid = 1'($urandom_range(0, 1));
            b_valid = 1'($urandom_range(0, 1));
            a_addr = 4'($urandom); b_addr = 4'($urandom);
            a_data = $urandom; b_data = $urandom;
            cycle();
        end
        a_valid = 0; b_valid = 0;
        cycle(); cycle(); cycle();

        // reset while one entry is still held
        a_valid = 1; a_addr = 4'd4; a_data = 32'hAA;
        b_valid = 1; b_addr = 4'd6; b_data = 32'hBB;
        cycle();
        a_valid = 0; b_valid = 0;
        cycle();
        check("pre_reset_we", we, 1);
        #1;
        do_reset();
        for (int i = 0; i < 4; i++) cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout: simulation did not complete");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Write-side feeder for a single 1-write/1-read register bank.
- Merges two writeback producers into the bank's single write port: source A (ALU result) and source B (load data).
- Each source has a valid/ready handshake and a one-entry holding register.
- Arbitration is round-robin, and the write port outputs are registered.
- Optionally scrubs the whole bank to zero after reset, before granting any writeback.

Parameters:
- ADDR_W, 4, register address width (fp, sp, r0..r13).
- DATA_W, 32, register data width.
- DEPTH, 16, number of registers; must be ≤ 2**ADDR_W.

Ports:
- clock, input, 1, sole clock; all state changes on its rising edge.
- reset_n, input, 1, asynchronous active-low reset.
- a_valid, input, 1, source A has a writeback.
- a_ready, output, 1, source A holding register is empty.
- a_addr, input, ADDR_W, source A destination register.
- a_data, input, DATA_W, source A write value.
- b_valid, input, 1, source B has a writeback.
- b_ready, output, 1, source B holding register is empty.
- b_addr, input, ADDR_W, source B destination register.
- b_data, input, DATA_W, source B write value.
- we, output, 1, bank write enable (registered).
- write_addr, output, ADDR_W, bank write address (registered).
- write_data, output, DATA_W, bank write data (registered).
- init_done, output, 1, high once the block is in RUN.

Behaviour:
- Reset values: we=0, write_addr=0, write_data=0, a_ready=0, b_ready=0, holding registers empty, round-robin pointer=A.
  - Feature compiled in: init_done=0, state INIT, scrub index=0.
  - Feature compiled out: init_done=1, state RUN.
- States are INIT and RUN; there are no other transitions.
- Handshake:
  - x_ready = (state==RUN) && !hold_x_full. It is a registered or flop-derived signal, never combinational from x_valid.
  - A transfer occurs on a clock edge where x_valid && x_ready; addr and data are captured into hold_x.
- Arbitration (RUN), each cycle:
  - Only one holding register full: it is granted.
  - Both full: the pointer's source is granted, then the pointer flips to the other source.
  - Single-source grants do not move the pointer.
- Grant effect: on the same edge, we<=1 and write_addr/write_data<=hold contents, and that hold is cleared. The hold may refill on the following edge, so each source sustains one write every 2 cycles.
- No grant in a cycle: we<=0; write_addr/write_data keep their previous values.
- Latency: accept edge N -> earliest we high in the cycle after edge N+1.
- Simultaneous same-address holds: both writes are issued, in round-robin order. The later one wins in the bank, and the block does no merging. Producers own ordering.
- Simultaneous grant and new accept on the other source: allowed; the accepted entry waits in its hold.
- Asynchronous reset mid-operation: held entries are discarded, we drops immediately, and the state returns to its reset state.
- Width rules: addresses ≥ DEPTH are passed through unchanged and never checked.

Optional Feature:
- Macro: REGFILE_WB_ARBITER_SCRUB_EN.
- Defined:
  - INIT issues we=1, write_addr=index, write_data=0 on consecutive cycles for index 0..DEPTH-1 (DEPTH cycles).
  - The index increments with no wrap; after the DEPTH-1 write the next edge enters RUN with init_done=1, we=0.
  - a_ready/b_ready stay 0 throughout INIT.
- Undefined: no INIT state or index counter; RUN starts at reset release.

Decomposition:
- Shared package: state encoding constants (ST_INIT, ST_RUN), default ADDR_W/DATA_W/DEPTH, and the writeback request struct/typedef {addr, data}.
- One natural sub-module: wb_hold_slot, the one-entry holding register with valid/ready. It is instantiated twice (A, B).

Test Plan:
- Scrub: release reset with SCRUB_EN -> we=1 for exactly 16 cycles with addr 0..15, data 0. Then init_done=1, we=0, and a_ready/b_ready rise.
- Single source: A sends {addr=3, data=0xDEADBEEF} -> one cycle later we=1, write_addr=3, write_data=0xDEADBEEF for one cycle. a_ready is low for one cycle.
- Conflict: A {2, 0x11} and B {5, 0x22} accepted on the same edge -> A written first, then B next cycle. Repeating this gives B first (pointer alternation).
- Same address: A {7, 0x1} and B {7, 0x2} accepted together with pointer=A -> writes 0x1 then 0x2 to addr 7 on consecutive cycles.
- Back-to-back: B valid continuously with data 1, 2, 3 -> accepts every other cycle; we pattern 1,0,1,0,...; data in order.
- Reset mid-operation: assert reset_n=0 while A is held -> we=0 immediately. The held entry is never written after release; INIT restarts when SCRUB_EN is defined.
